// File: rtl/msg_schedule.sv
// msg_schedule: SHA-256 message schedule generator.
// Fetches 16 message words from a 1-cycle synchronous SRAM, streams them out
// as W[0..15], then expands and streams W[16..63], one word per cycle.
// A sticky done flag marks the end of the run until the next reset.
//
// Optional build macro MSG_BYTE_SWAP_EN: when defined, every word read from the
// SRAM is byte-reversed before use (little-endian message memories). When it
// is undefined, msg_data is used unchanged.
module msg_schedule #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [31:0]           msg_data,
  output logic                  msg_rd,
  output logic [ADDR_WIDTH-1:0] msg_addr,
  output logic [31:0]           w_out,
  output logic                  w_valid,
  output logic [5:0]            round_idx,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  rd_idx;    // index of the read currently being issued
  logic        rd_q;      // msg_rd delayed one cycle: msg_data is valid now
  logic [5:0]  t_idx;     // index of the next word to be registered
  logic [31:0] win [16];  // win[0] = W[t-16] ... win[15] = W[t-1]

  logic [31:0] data_in;
  logic [31:0] w_next;

  // Small sigma functions of FIPS 180-4.
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Present the SRAM word in the schedule's big-endian word order.
`ifdef MSG_BYTE_SWAP_EN
  assign data_in = {msg_data[7:0], msg_data[15:8], msg_data[23:16], msg_data[31:24]};
`else
  assign data_in = msg_data;
`endif

  // Expansion term for W[t] from the sliding 16-word window.
  assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  // Control FSM, SRAM read sequencing, window shift and registered outputs.
  // NOTE: all state here is updated with non-blocking assignments so every
  // flop samples pre-edge values; the window shift depends on that ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      msg_rd    <= 1'b0;
      msg_addr  <= BASE_ADDR;
      w_out     <= '0;
      w_valid   <= 1'b0;
      round_idx <= '0;
      done      <= 1'b0;
      rd_idx    <= '0;
      rd_q      <= 1'b0;
      t_idx     <= '0;
      // NOTE: the window is a register file, not SRAM, so it is cleared here
      // like every other flop; a fresh run never sees stale words.
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      rd_q <= msg_rd;
      case (state)
        S_IDLE: begin
          w_valid <= 1'b0;
          if (enable) begin
            state    <= S_LOAD;
            msg_rd   <= 1'b1;
            msg_addr <= BASE_ADDR;
            rd_idx   <= '0;
            t_idx    <= '0;
          end
        end

        S_LOAD: begin
          // Issue reads BASE_ADDR+0 .. BASE_ADDR+15; the address wraps freely.
          if (msg_rd) begin
            if (rd_idx == 4'd15) begin
              msg_rd <= 1'b0;
            end else begin
              rd_idx   <= rd_idx + 4'd1;
              msg_addr <= msg_addr + ADDR_WIDTH'(1);
            end
          end
          // Capture the word read in the previous cycle.
          if (rd_q) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15]   <= data_in;
            w_out     <= data_in;
            w_valid   <= 1'b1;
            round_idx <= t_idx;
            t_idx     <= t_idx + 6'd1;
            if (t_idx == 6'd15) state <= S_EXPAND;
          end else begin
            w_valid <= 1'b0;
          end
        end

        S_EXPAND: begin
          for (int i = 0; i < 15; i++) win[i] <= win[i+1];
          win[15]   <= w_next;
          w_out     <= w_next;
          w_valid   <= 1'b1;
          round_idx <= t_idx;
          t_idx     <= t_idx + 6'd1;
          if (t_idx == 6'd63) state <= S_DONE;
        end

        S_DONE: begin
          // Terminal until reset; enable is ignored and w_out keeps W[63].
          msg_rd  <= 1'b0;
          w_valid <= 1'b0;
          done    <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: two instances (BASE_ADDR 0 and 8'hF8)
// share clock, reset and enable, each with its own SRAM model holding the
// "abc" message block. Expected words come from hand values and a reference
// recurrence computed in the bench.
module tb_msg_schedule;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;

  logic [31:0] rdata_a, rdata_b;
  logic        msg_rd_a, msg_rd_b;
  logic [7:0]  msg_addr_a, msg_addr_b;
  logic [31:0] w_out_a, w_out_b;
  logic        w_valid_a, w_valid_b;
  logic [5:0]  round_idx_a, round_idx_b;
  logic        done_a, done_b;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] msg_w [16];
  logic [31:0] ref_w [64];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  msg_schedule #(.ADDR_WIDTH(8), .BASE_ADDR(8'h00)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .msg_data(rdata_a),
    .msg_rd(msg_rd_a), .msg_addr(msg_addr_a), .w_out(w_out_a),
    .w_valid(w_valid_a), .round_idx(round_idx_a), .done(done_a)
  );

  msg_schedule #(.ADDR_WIDTH(8), .BASE_ADDR(8'hF8)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .msg_data(rdata_b),
    .msg_rd(msg_rd_b), .msg_addr(msg_addr_b), .w_out(w_out_b),
    .w_valid(w_valid_b), .round_idx(round_idx_b), .done(done_b)
  );

  // Synchronous SRAM models with one cycle of read latency.
  always @(posedge clock) if (msg_rd_a) rdata_a <= mem_a[msg_addr_a];
  always @(posedge clock) if (msg_rd_b) rdata_b <= mem_b[msg_addr_b];

  // Hard stop in case a wait escapes its bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] stored(input logic [31:0] x);
`ifdef MSG_BYTE_SWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  // Hand-computed words take precedence; the rest come from the recurrence.
  function automatic logic [31:0] exp_word(input int i);
    case (i)
      0:       return 32'h61626380;
      15:      return 32'h00000018;
      16:      return 32'h61626380;
      17:      return 32'h000F0000;
      18:      return 32'h7DA86405;
      default: return ref_w[i];
    endcase
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_rd_a"},    32'(msg_rd_a),    32'd0);
    chk({tag, "_addr_a"},  32'(msg_addr_a),  32'h00);
    chk({tag, "_w_a"},     w_out_a,          32'd0);
    chk({tag, "_valid_a"}, 32'(w_valid_a),   32'd0);
    chk({tag, "_idx_a"},   32'(round_idx_a), 32'd0);
    chk({tag, "_done_a"},  32'(done_a),      32'd0);
    chk({tag, "_addr_b"},  32'(msg_addr_b),  32'hF8);
    chk({tag, "_w_b"},     w_out_b,          32'd0);
  endtask

  // Raise enable in cycle 0 and follow the whole run, L0..L69.
  task automatic run_full(input bit drop_en);
    int         vcount = 0;
    int         rcount = 0;
    int         first_v = -1;
    int         idx = 0;
    logic [7:0] ab;
    @(negedge clock);
    enable = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clock);
      if (k < 16) begin
        ab = 8'hF8;
        ab = ab + 8'(k);
        chk("rd_a_load", 32'(msg_rd_a),   32'd1);
        chk("addr_a",    32'(msg_addr_a), 32'(k));
        chk("addr_b",    32'(msg_addr_b), 32'(ab));
      end
      if (k == 16) chk("rd_a_drop", 32'(msg_rd_a), 32'd0);
      if (msg_rd_a) rcount++;
      if (w_valid_a) begin
        if (first_v < 0) first_v = k;
        chk("round_idx", 32'(round_idx_a), 32'(idx));
        chk("w_a", w_out_a, exp_word(idx));
        chk("w_b", w_out_b, exp_word(idx));
        idx++;
        vcount++;
        if (drop_en && idx == 21) enable = 1'b0;
      end
      if (k == 65) chk("done_before_l66", 32'(done_a), 32'd0);
      if (k == 66) begin
        chk("done_l66",   32'(done_a),    32'd1);
        chk("valid_l66",  32'(w_valid_a), 32'd0);
        chk("w_hold_l66", w_out_a,        ref_w[63]);
      end
    end
    chk("valid_count", 32'(vcount),  32'd64);
    chk("rd_count",    32'(rcount),  32'd16);
    chk("first_valid", 32'(first_v), 32'd2);
    chk("done_sticky", 32'(done_a),  32'd1);
    chk("done_b",      32'(done_b),  32'd1);
  endtask

  initial begin
    // Message block for "abc" and its reference schedule.
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int i = 0; i < 16; i++) msg_w[i] = '0;
    msg_w[0]  = 32'h61626380;
    msg_w[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) begin
      ref_w[i]                 = msg_w[i];
      mem_a[i]                 = stored(msg_w[i]);
      mem_b[(248 + i) % 256]   = stored(msg_w[i]);
    end
    for (int t = 16; t < 64; t++)
      ref_w[t] = s1(ref_w[t-2]) + ref_w[t-7] + s0(ref_w[t-15]) + ref_w[t-16];

    // Reset together with enable: reset wins.
    reset  = 1'b1;
    enable = 1'b1;
    #12;
    check_reset("por");
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_rd",    32'(msg_rd_a),  32'd0);
    chk("idle_valid", 32'(w_valid_a), 32'd0);

    // Run 1: enable dropped after round 20; run must still complete.
    run_full(1'b1);

    // Enable while in DONE is ignored.
    enable = 1'b1;
    repeat (4) @(negedge clock);
    chk("done_ign_rd",    32'(msg_rd_a),  32'd0);
    chk("done_ign_valid", 32'(w_valid_a), 32'd0);
    chk("done_ign_done",  32'(done_a),    32'd1);
    chk("done_ign_w",     w_out_a,        ref_w[63]);

    // Asynchronous reset mid-cycle, no clock edge.
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check_reset("rst_done");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Run 2: abort with reset at round 30.
    begin
      bit found = 1'b0;
      enable = 1'b1;
      for (int k = 0; k < 80 && !found; k++) begin
        @(negedge clock);
        if (w_valid_a && round_idx_a == 6'd30) found = 1'b1;
      end
      chk("reach_round30", 32'(found), 32'd1);
      chk("w_round30", w_out_a, ref_w[30]);
      reset  = 1'b1;
      enable = 1'b0;
      #1;
      check_reset("rst_mid");
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("post_rst_rd",   32'(msg_rd_a), 32'd0);
      chk("post_rst_done", 32'(done_a),   32'd0);
    end

    // Run 3: full restart with enable held high throughout.
    run_full(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
